// File: rtl/conv_window_feeder_pkg.sv
// Shared types and constants for the convolution window feeder.
// Imported by the interface, the line buffer and the top level.
package conv_feeder_pkg;

  localparam int PIX_W = 8;
  localparam int TAPS  = 9;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    SEND_W,
    READY,
    STREAM
  } feeder_state_t;

  // Flat tap index for a window row/column; row-major, 0 is the top-left tap.
  function automatic int tap_idx(input int row, input int col);
    return row * 3 + col;
  endfunction

endpackage

// File: rtl/conv_window_feeder_if.sv
// Kernel/pixel input stream and Convolution-facing kernel/window outputs.
// master = the pixel/kernel source, slave = the feeder.
interface conv_window_feeder_if;
  import conv_feeder_pkg::*;

  logic w_valid;
  pix_t w_data;
  logic pix_valid;
  pix_t pix_data;

  logic weight_valid;
  pix_t In_Weight_1, In_Weight_2, In_Weight_3;
  pix_t In_Weight_4, In_Weight_5, In_Weight_6;
  pix_t In_Weight_7, In_Weight_8, In_Weight_9;

  logic in_valid;
  pix_t In_IFM_1, In_IFM_2, In_IFM_3;
  pix_t In_IFM_4, In_IFM_5, In_IFM_6;
  pix_t In_IFM_7, In_IFM_8, In_IFM_9;

  logic frame_done;
  logic err;

  modport master (
    output w_valid, w_data, pix_valid, pix_data,
    input  weight_valid,
    input  In_Weight_1, In_Weight_2, In_Weight_3, In_Weight_4, In_Weight_5,
    input  In_Weight_6, In_Weight_7, In_Weight_8, In_Weight_9,
    input  in_valid,
    input  In_IFM_1, In_IFM_2, In_IFM_3, In_IFM_4, In_IFM_5,
    input  In_IFM_6, In_IFM_7, In_IFM_8, In_IFM_9,
    input  frame_done, err
  );

  modport slave (
    input  w_valid, w_data, pix_valid, pix_data,
    output weight_valid,
    output In_Weight_1, In_Weight_2, In_Weight_3, In_Weight_4, In_Weight_5,
    output In_Weight_6, In_Weight_7, In_Weight_8, In_Weight_9,
    output in_valid,
    output In_IFM_1, In_IFM_2, In_IFM_3, In_IFM_4, In_IFM_5,
    output In_IFM_6, In_IFM_7, In_IFM_8, In_IFM_9,
    output frame_done, err
  );

endinterface

// File: rtl/conv_window_feeder_line_buffer.sv
// One image row of pixel storage; registered read, read-before-write.
// Separate read and write addresses so the next column can be fetched ahead.
module conv_line_buffer
  import conv_feeder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk1,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  pix_t          wr_data,
  input  logic [AW-1:0] rd_addr,
  output pix_t          rd_data
);

  pix_t mem_q [DEPTH];
  pix_t rd_data_q;

  always_ff @(posedge clk1) begin
    if (we) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/conv_window_feeder.sv
// Collects a serial 3x3 kernel and a raster pixel stream, presents the kernel
// once in parallel, then emits one valid-padding 3x3 window per eligible pixel.
module conv_window_feeder
  import conv_feeder_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic               clk1,
  input  logic               rst,
  conv_window_feeder_if.slave bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int KW = $clog2(TAPS);

  feeder_state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [KW-1:0] kcnt_q, kcnt_d;

  pix_t kbuf_q   [TAPS];
  pix_t kbuf_d   [TAPS];
  pix_t weight_q [TAPS];
  pix_t weight_d [TAPS];
  pix_t ifm_q    [TAPS];
  pix_t ifm_d    [TAPS];
  pix_t win_q    [3][3];
  pix_t win_d    [3][3];

  logic weight_valid_q, weight_valid_d;
  logic in_valid_q, in_valid_d;
  logic frame_done_q, frame_done_d;
  logic err_q, err_d;

  logic load_beat;
  logic accept;

  // lb_rd[0] holds row r-1, lb_rd[1] holds row r-2, both at the incoming column.
  pix_t lb_rd   [2];
  pix_t lb_wd   [2];
  pix_t new_col [3];

  assign lb_wd[0] = bus.pix_data;
  assign lb_wd[1] = lb_rd[0];

  // Read address tracks the column of the next pixel so data is ready on arrival.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lb
    conv_line_buffer #(
      .DEPTH (IMG_W),
      .AW    (CW)
    ) u_lb (
      .clk1    (clk1),
      .we      (accept),
      .wr_addr (col_q),
      .wr_data (lb_wd[gi]),
      .rd_addr (col_d),
      .rd_data (lb_rd[gi])
    );
  end

  assign new_col[0] = lb_rd[1];
  assign new_col[1] = lb_rd[0];
  assign new_col[2] = bus.pix_data;

  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    row_d          = row_q;
    kcnt_d         = kcnt_q;
    kbuf_d         = kbuf_q;
    weight_d       = weight_q;
    ifm_d          = ifm_q;
    win_d          = win_q;
    weight_valid_d = 1'b0;
    in_valid_d     = 1'b0;
    frame_done_d   = 1'b0;
    err_d          = err_q;
    load_beat      = 1'b0;
    accept         = 1'b0;

    case (state_q)
      IDLE, LOAD_W: begin
        load_beat = bus.w_valid;
        if (bus.pix_valid) err_d = 1'b1;
      end
      SEND_W: begin
        // Nothing is accepted during the one-cycle kernel presentation.
        state_d = READY;
        if (bus.pix_valid || bus.w_valid) err_d = 1'b1;
      end
      READY: begin
        if (bus.w_valid) begin
          load_beat = 1'b1;
          if (bus.pix_valid) err_d = 1'b1;
        end else if (bus.pix_valid) begin
          accept  = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        accept = bus.pix_valid;
        if (bus.w_valid) err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (load_beat) begin
      for (int i = 0; i < TAPS - 1; i++) begin
        kbuf_d[i] = kbuf_q[i+1];
      end
      kbuf_d[TAPS-1] = bus.w_data;
      if (state_q == LOAD_W && kcnt_q == KW'(TAPS - 1)) begin
        weight_d       = kbuf_d;
        weight_valid_d = 1'b1;
        kcnt_d         = '0;
        state_d        = SEND_W;
      end else begin
        kcnt_d  = (state_q == LOAD_W) ? kcnt_q + KW'(1) : KW'(1);
        state_d = LOAD_W;
      end
    end

    if (accept) begin
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
        win_d[i][2] = new_col[i];
      end
      if (row_q >= RW'(2) && col_q >= CW'(2)) begin
        in_valid_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            ifm_d[tap_idx(i, j)] = win_d[i][j];
          end
        end
      end
      if (col_q == CW'(IMG_W - 1)) begin
        col_d = '0;
        if (row_q == RW'(IMG_H - 1)) begin
          row_d        = '0;
          frame_done_d = 1'b1;
          state_d      = READY;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q        <= IDLE;
      col_q          <= '0;
      row_q          <= '0;
      kcnt_q         <= '0;
      weight_valid_q <= 1'b0;
      in_valid_q     <= 1'b0;
      frame_done_q   <= 1'b0;
      err_q          <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        kbuf_q[i]   <= '0;
        weight_q[i] <= '0;
        ifm_q[i]    <= '0;
      end
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      row_q          <= row_d;
      kcnt_q         <= kcnt_d;
      weight_valid_q <= weight_valid_d;
      in_valid_q     <= in_valid_d;
      frame_done_q   <= frame_done_d;
      err_q          <= err_d;
      kbuf_q         <= kbuf_d;
      weight_q       <= weight_d;
      ifm_q          <= ifm_d;
      win_q          <= win_d;
    end
  end

  assign bus.weight_valid = weight_valid_q;
  assign bus.in_valid     = in_valid_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.err          = err_q;

  assign bus.In_Weight_1 = weight_q[0];
  assign bus.In_Weight_2 = weight_q[1];
  assign bus.In_Weight_3 = weight_q[2];
  assign bus.In_Weight_4 = weight_q[3];
  assign bus.In_Weight_5 = weight_q[4];
  assign bus.In_Weight_6 = weight_q[5];
  assign bus.In_Weight_7 = weight_q[6];
  assign bus.In_Weight_8 = weight_q[7];
  assign bus.In_Weight_9 = weight_q[8];

  assign bus.In_IFM_1 = ifm_q[0];
  assign bus.In_IFM_2 = ifm_q[1];
  assign bus.In_IFM_3 = ifm_q[2];
  assign bus.In_IFM_4 = ifm_q[3];
  assign bus.In_IFM_5 = ifm_q[4];
  assign bus.In_IFM_6 = ifm_q[5];
  assign bus.In_IFM_7 = ifm_q[6];
  assign bus.In_IFM_8 = ifm_q[7];
  assign bus.In_IFM_9 = ifm_q[8];

endmodule

// File: doc/conv_window_feeder.md
# conv_window_feeder

Stimulus-side counterpart of the `Convolution` core's input interface: the transmitter for its `weight_valid`/`In_Weight_*` and `in_valid`/`In_IFM_*` receiver. It accepts a serial 9-byte kernel and a raster-order 8-bit pixel stream. It presents the kernel once as a 9-byte parallel word, then emits one 3x3 valid-padding window per eligible pixel. It sits in the `clk1` domain directly in front of `Convolution` and replaces the bench-only pattern source in system builds.

## Interface
- `IMG_W`, default 8: pixels per row; must be ≥ 3.
- `IMG_H`, default 8: rows per frame; must be ≥ 3.
- `clk1`, input, 1: sole clock; all logic rises on it.
- `rst`, input, 1: reset, synchronous, active-high.
- `w_valid`, input, 1: kernel byte strobe.
- `w_data`, input, 8: kernel byte; row-major, first byte is the top-left tap.
- `pix_valid`, input, 1: pixel strobe. There is no backpressure.
- `pix_data`, input, 8: pixel, raster order.
- `weight_valid`, output, 1: one-cycle kernel presentation.
- `In_Weight_1`..`In_Weight_9`, output, 8 each: kernel taps, row-major; `_1` is top-left.
- `in_valid`, output, 1: window strobe.
- `In_IFM_1`..`In_IFM_9`, output, 8 each: window, row-major; `_1` is top-left.
- `frame_done`, output, 1: one-cycle pulse with the last window of a frame.
- `err`, output, 1: sticky protocol-error flag; cleared only by `rst`.

## Operation
- **States**
  - `IDLE`: no kernel held. `w_valid` moves to `LOAD_W`. `pix_valid` is dropped and sets `err`.
  - `LOAD_W`: counts 9 `w_valid` beats. Beats may be non-consecutive. After the 9th beat, go to `SEND_W`. `pix_valid` is dropped and sets `err`.
  - `SEND_W`: lasts one cycle. `weight_valid`=1, then go to `READY`.
  - `READY`: kernel held.
    - `pix_valid` is accepted as pixel (0,0) and moves to `STREAM`.
    - `w_valid` discards the held kernel and goes to `LOAD_W` (beat counts as 1).
    - If both are high, `w_valid` wins, the pixel is dropped, and `err` is set.
  - `STREAM`: accepts pixels and advances column/row counters (c wraps at IMG_W-1, r increments). After pixel (IMG_H-1, IMG_W-1), return to `READY`. `w_valid` in `STREAM` is ignored and sets `err`.
- **Window formation**
  - Two line buffers hold rows r-1 and r-2. A 3x3 register array shifts left one column per accepted pixel.
  - The new column is {row r-2 at c, row r-1 at c, `pix_data`}. The line buffers then write: row r-1 into the r-2 buffer, and the pixel into the r-1 buffer, both at c.
  - A window is emitted only when the accepted pixel has r ≥ 2 and c ≥ 2. No padding. This gives (IMG_W-2)(IMG_H-2) windows per frame.
  - `In_IFM_k` equals pixel (r-2+(k-1)/3, c-2+(k-1)%3).
  - Windows never straddle rows, because c ≥ 2 guarantees all three columns are in the current row.
- **Outputs between strobes**
  - `In_Weight_*` hold the kernel from `SEND_W` until the next kernel load completes.
  - `In_IFM_*` hold the last window. They carry no meaning when `in_valid`=0.

## Timing
- **Reset:** every output is 0. State returns to `IDLE`. Counters, window array, held kernel and `err` are cleared. Line-buffer contents are don't-care. A reset mid-frame or mid-load abandons it; no partial window is emitted afterwards.
- **Kernel latency:** 9th `w_valid` at cycle t gives `weight_valid`=1 at t+1. `READY` is entered at t+2. A pixel is first accepted at t+2.
- **Window latency:** pixel accepted at t gives `in_valid` at t+1. The throughput is one window per cycle for back-to-back pixels.
- **Frame end:** last pixel at t gives `in_valid`=`frame_done`=1 at t+1. A new frame's pixel (0,0) may arrive at t+1.
- **Strobe spacing:** `weight_valid` and `in_valid` are never high in the same cycle.

## Structure
- Package `conv_feeder_pkg`: `PIX_W`=8, `TAPS`=9, state enum (`IDLE`, `LOAD_W`, `SEND_W`, `READY`, `STREAM`).
- Sub-module `conv_line_buffer`: depth `IMG_W`, 8-bit, single write/read address per cycle, read-before-write. Instantiated twice.
- The top level holds the FSM, counters, the 3x3 array and the output registers.

## Test plan
- **Kernel load:** kernel bytes 1..9 on consecutive cycles → one `weight_valid` cycle, `In_Weight_1`=1 … `In_Weight_9`=9, state `READY`.
- **Full frame:** 8x8 frame, pixel value = 8r+c, back-to-back.
  - Exactly 36 `in_valid` pulses.
  - First window = {0,1,2,8,9,10,16,17,18}.
  - Last window = {45,46,47,53,54,55,61,62,63} with `frame_done`.
- **Gapped input:** same frame with `pix_valid` low every other cycle → identical window sequence; each window arrives one cycle after its pixel.
- **Protocol errors:**
  - `pix_valid` in `IDLE` → dropped, `err`=1, no `in_valid`.
  - Simultaneous `w_valid`/`pix_valid` in `READY` → `LOAD_W` entered, `err`=1.
- **Mid-frame reset:** `rst` after 30 pixels → all outputs 0 next cycle. Reload the kernel and a fresh frame → the 36 correct windows, with no stale data.
- **Back-to-back frames:** two frames with no gap → 72 windows and 2 `frame_done` pulses; the first window of frame 2 uses only frame-2 pixels.
